// File: rtl/branch_unit_if.sv
// Bus between the EX stage / front end and branch_unit: EX operands,
// comparator flags, prediction lookup, redirect/flush and statistics.
interface branch_unit_if;
    logic [31:0] i_if_pc;
    logic        o_pred_taken;
    logic        i_ex_valid;
    logic        i_stall;
    logic        i_ex_branch;
    logic        i_ex_jump;
    logic [2:0]  i_ex_funct3;
    logic [31:0] i_ex_pc;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic        o_brUn;
    logic        i_brEq;
    logic        i_brLT;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_flush;
    logic [31:0] o_br_count;
    logic [31:0] o_mispredict_count;

    modport master (
        output i_if_pc, i_ex_valid, i_stall, i_ex_branch, i_ex_jump, i_ex_funct3,
               i_ex_pc, i_ex_target, i_ex_pred_taken, i_brEq, i_brLT,
        input  o_pred_taken, o_brUn, o_redirect, o_redirect_pc, o_flush,
               o_br_count, o_mispredict_count
    );

    modport slave (
        input  i_if_pc, i_ex_valid, i_stall, i_ex_branch, i_ex_jump, i_ex_funct3,
               i_ex_pc, i_ex_target, i_ex_pred_taken, i_brEq, i_brLT,
        output o_pred_taken, o_brUn, o_redirect, o_redirect_pc, o_flush,
               o_br_count, o_mispredict_count
    );
endinterface

// File: rtl/branch_unit.sv
// EX-stage branch resolution: outcome, registered redirect + multi-cycle flush,
// statistics, and a 2-bit BHT that exists only when BRANCH_UNIT_BHT_EN is defined.
module branch_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned BHT_BITS     = 4
) (
    input logic          i_clk,
    input logic          i_rst,
    branch_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t      r_state;
    logic [CW-1:0] r_flush_cnt;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;
    logic        r_flush;
    logic [31:0] r_br_count;
    logic [31:0] r_mis_count;

    logic        w_taken;
    logic        w_cond_valid;
    logic        w_resolve;
    logic        w_is_br;
    logic        w_pred;
    logic        w_mispredict;
    logic        w_redirect_req;
    logic [31:0] w_redirect_pc;
    logic        w_unused;

    assign bus.o_brUn = (bus.i_ex_funct3[2:1] == 2'b11);

    always_comb begin
        w_taken      = 1'b0;
        w_cond_valid = 1'b1;
        case (bus.i_ex_funct3)
            3'b000:          w_taken = bus.i_brEq;
            3'b001:          w_taken = !bus.i_brEq;
            3'b100, 3'b110:  w_taken = bus.i_brLT;
            3'b101, 3'b111:  w_taken = !bus.i_brLT;
            default:         w_cond_valid = 1'b0;
        endcase
    end

    assign w_resolve = bus.i_ex_valid && !bus.i_stall && (r_state == S_IDLE)
                       && (bus.i_ex_branch || bus.i_ex_jump);
    // Jump wins when both qualifiers are set.
    assign w_is_br        = bus.i_ex_branch && !bus.i_ex_jump;
    assign w_mispredict   = w_is_br && (w_taken != w_pred);
    assign w_redirect_req = w_resolve && (bus.i_ex_jump || w_mispredict);
    assign w_redirect_pc  = (bus.i_ex_jump || w_taken) ? bus.i_ex_target
                                                       : bus.i_ex_pc + 32'd4;

`ifdef BRANCH_UNIT_BHT_EN
    logic [1:0]          r_bht [2**BHT_BITS];
    logic [BHT_BITS-1:0] w_ex_idx;
    logic [BHT_BITS-1:0] w_if_idx;
    logic                w_bht_we;

    assign w_ex_idx          = bus.i_ex_pc[BHT_BITS+1:2];
    assign w_if_idx          = bus.i_if_pc[BHT_BITS+1:2];
    assign w_bht_we          = w_resolve && w_is_br && w_cond_valid;
    assign w_pred            = bus.i_ex_pred_taken;
    assign bus.o_pred_taken  = r_bht[w_if_idx][1];
    assign w_unused          = ^{bus.i_if_pc[31:BHT_BITS+2], bus.i_if_pc[1:0]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < 2**BHT_BITS; i++) r_bht[i] <= 2'b01;
        end else if (w_bht_we) begin
            if (w_taken) begin
                if (r_bht[w_ex_idx] != 2'b11) r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'd1;
            end else begin
                if (r_bht[w_ex_idx] != 2'b00) r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'd1;
            end
        end
    end
`else
    assign w_pred           = 1'b0;
    assign bus.o_pred_taken = 1'b0;
    assign w_unused         = ^{bus.i_if_pc, bus.i_ex_pred_taken, w_cond_valid};
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_flush_cnt   <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_flush       <= 1'b0;
            r_br_count    <= '0;
            r_mis_count   <= '0;
        end else begin
            r_redirect <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_resolve && w_is_br) begin
                        r_br_count <= r_br_count + 32'd1;
                        if (w_mispredict) r_mis_count <= r_mis_count + 32'd1;
                    end
                    if (w_redirect_req) begin
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= w_redirect_pc;
                        r_flush       <= 1'b1;
                        r_flush_cnt   <= CW'(FLUSH_CYCLES);
                        r_state       <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt - CW'(1);
                    if (r_flush_cnt == CW'(1)) begin
                        r_flush <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_redirect         = r_redirect;
    assign bus.o_redirect_pc      = r_redirect_pc;
    assign bus.o_flush            = r_flush;
    assign bus.o_br_count         = r_br_count;
    assign bus.o_mispredict_count = r_mis_count;
endmodule

// File: doc/branch_unit.md
# branch_unit

Branch resolution unit for the EX stage of the rv32 pipeline. It drives the comparator's unsigned-select and consumes its equal/less-than flags. It decides the actual outcome of conditional branches and jumps, issues a registered PC redirect plus a multi-cycle front-end flush on mispredict, and maintains a 2-bit saturating branch history table (BHT) whose prediction feeds the fetch/decode front end.

## Interface
- FLUSH_CYCLES, 2, cycles o_flush stays asserted after a redirect (≥1)
- BHT_BITS, 4, log2 of BHT entry count; index = pc[BHT_BITS+1:2]
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_if_pc  in  32  fetch PC for prediction lookup
- o_pred_taken  out  1  prediction for i_if_pc (combinational read of BHT)
- i_ex_valid  in  1  EX holds a valid instruction
- i_stall  in  1  pipeline stall; EX contents held, no resolution
- i_ex_branch  in  1  conditional branch in EX
- i_ex_jump  in  1  JAL/JALR in EX
- i_ex_funct3  in  3  branch funct3
- i_ex_pc  in  32  PC of EX instruction
- i_ex_target  in  32  computed branch/jump target
- i_ex_pred_taken  in  1  prediction carried down the pipe with this instruction
- o_brUn  out  1  comparator unsigned select: 1 for funct3 110/111, else 0
- i_brEq  in  1  comparator equal flag
- i_brLT  in  1  comparator less-than flag
- o_redirect  out  1  one-cycle PC redirect strobe
- o_redirect_pc  out  32  redirect address, valid with o_redirect
- o_flush  out  1  kill IF/ID (and EX input) wrong-path instructions
- o_br_count  out  32  resolved conditional branches
- o_mispredict_count  out  32  mispredicted conditional branches

## Operation
- Outcome: 000 BEQ=Eq; 001 BNE=!Eq; 100 BLT/110 BLTU=LT; 101 BGE/111 BGEU=!LT; 010/011 → not taken, no BHT update, still counted.
- Resolve event: i_ex_valid & !i_stall & state==IDLE & (i_ex_branch | i_ex_jump). i_ex_branch and i_ex_jump both high → treat as jump.
- Conditional branch: mispredict = taken != i_ex_pred_taken. Redirect target is i_ex_target if taken, else i_ex_pc+4 (32-bit wrap). o_br_count += 1; o_mispredict_count += 1 on mispredict.
- Jump: always redirect to i_ex_target; no counters, no BHT update.
- BHT update on every conditional-branch resolve: taken → counter+1, saturating at 3; not taken → counter−1, saturating at 0. Prediction = counter[1].
- Same-cycle lookup and update of the same index: lookup returns the pre-update value (no bypass).
- FSM states:
  - IDLE: a redirect-causing resolve → FLUSH, with flush counter loaded to FLUSH_CYCLES.
  - FLUSH: counter decrements every cycle regardless of i_stall; on reaching 0 → IDLE.
  - While in FLUSH, all EX inputs are ignored: no resolve, no counter updates, no BHT updates.
- Counters wrap modulo 2^32.

## Timing
- o_brUn is combinational from i_ex_funct3; comparator flags are used in the same cycle.
- Latency: resolve sampled at edge N. o_redirect and o_redirect_pc are valid during cycle N+1 only. o_flush is high for cycles N+1 through N+FLUSH_CYCLES.
- A correctly predicted branch produces no redirect and no flush; back-to-back resolves are accepted every cycle in IDLE.
- Counters and BHT update at the resolve edge and are visible in cycle N+1.
- Reset (asynchronous, any time including mid-FLUSH):
  - state=IDLE.
  - o_redirect=0, o_redirect_pc=0, o_flush=0.
  - both counters=0.
  - every BHT entry=2'b01 (weakly not taken), so o_pred_taken=0.

## Configuration
- BRANCH_UNIT_BHT_EN defined:
  - BHT present as described.
- BRANCH_UNIT_BHT_EN undefined:
  - No BHT storage; o_pred_taken tied 0.
  - Mispredict = taken (static not-taken). i_ex_pred_taken is ignored and treated as 0.
  - Counters, FSM and jump handling are unchanged.

## Test plan
- Reset: o_redirect=0, o_flush=0, counters=0, o_pred_taken=0 for any i_if_pc.
- BEQ at pc=0x100, target=0x200, Eq=1, pred=0 → cycle N+1: o_redirect=1, o_redirect_pc=0x200; o_flush high 2 cycles; o_mispredict_count=1; BHT[0] goes 01→10.
- BLTU funct3=110 → o_brUn=1. BGE pc=0x104, pred=1, LT=1 → redirect to 0x108.
- Valid branch presented during FLUSH → ignored: no counter change, no extra redirect.
- Four taken branches at one pc → counter saturates at 3, o_pred_taken=1. Five not-taken branches → saturates at 0.
- Assert i_rst mid-FLUSH → o_flush drops immediately, state IDLE, counters 0. BRANCH_UNIT_BHT_EN undefined build: taken BNE with pred=1 still counts as mispredict.
